// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// A winner keeps the port for up to MAX_BURST words, until req_last, or until it drops req.
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       ack,
  input  logic                     fifo_full,
  output logic                     fifo_write_en,
  output logic [WIDTH-1:0]         fifo_write_data,
  output logic                     busy,
  output logic [7:0]               burst_count
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   next_owner;
  logic [IDX_W-1:0]   last_winner;
  logic [IDX_W-1:0]   next_last_winner;
  logic [NUM_REQ-1:0] next_grant;
  logic [7:0]         next_count;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand;
  logic               owner_req;
  logic               owner_last;
  logic               burst_done;

  // Search starts just after the previous winner so every pending requester gets a turn.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_winner) + k) % NUM_REQ);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    owner_req       = req[owner];
    owner_last      = req_last[owner];
    fifo_write_data = '0;
    if (state == BURST) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (owner == IDX_W'(i)) begin
          fifo_write_data = req_data[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign busy          = (state == BURST);
  assign fifo_write_en = busy && owner_req && !fifo_full;
  assign ack           = fifo_write_en ? grant : '0;

  // A stalled word (full) never ends the burst; only an accepted word or a dropped request does.
  assign burst_done = (fifo_write_en &&
                       (owner_last || (({1'b0, burst_count} + 9'd1) == 9'(MAX_BURST)))) ||
                      !owner_req;

  always_comb begin
    next_state       = state;
    next_owner       = owner;
    next_last_winner = last_winner;
    next_grant       = grant;
    next_count       = burst_count;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          next_state       = BURST;
          next_owner       = pick_idx;
          next_last_winner = pick_idx;
          next_grant       = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
          next_count       = '0;
        end
      end
      BURST: begin
        if (burst_done) begin
          next_state = IDLE;
          next_grant = '0;
          next_count = '0;
        end else if (fifo_write_en) begin
          next_count = burst_count + 8'd1;
        end
      end
      default: begin
        next_state = IDLE;
        next_grant = '0;
        next_count = '0;
      end
    endcase
  end

  // last_winner resets to the top index so requester 0 is favoured first.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      owner       <= '0;
      last_winner <= IDX_W'(NUM_REQ - 1);
      grant       <= '0;
      burst_count <= '0;
    end else begin
      state       <= next_state;
      owner       <= next_owner;
      last_winner <= next_last_winner;
      grant       <= next_grant;
      burst_count <= next_count;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: producers are modelled as word queues,
// expected FIFO writes are queued when stimulus is loaded and compared as they appear.
module tb_fifo_write_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;

  logic                     clock     = 1'b0;
  logic                     reset_n   = 1'b0;
  logic [NUM_REQ-1:0]       req       = '0;
  logic [NUM_REQ*WIDTH-1:0] req_data  = '0;
  logic [NUM_REQ-1:0]       req_last  = '0;
  logic                     fifo_full = 1'b0;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       ack;
  logic                     fifo_write_en;
  logic [WIDTH-1:0]         fifo_write_data;
  logic                     busy;
  logic [7:0]               burst_count;

  typedef struct {
    logic [3:0] grant;
    logic [7:0] data;
    logic [7:0] count;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] src_q[NUM_REQ][$];
  logic [3:0] ack_s = '0;
  int         checks = 0;
  int         errors = 0;

  fifo_write_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .WIDTH    (WIDTH),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .req            (req),
    .req_data       (req_data),
    .req_last       (req_last),
    .grant          (grant),
    .ack            (ack),
    .fifo_full      (fifo_full),
    .fifo_write_en  (fifo_write_en),
    .fifo_write_data(fifo_write_data),
    .busy           (busy),
    .burst_count    (burst_count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Producer model: a word leaves its queue once it was acked, the next word is presented after the edge.
  always @(negedge clock) ack_s = ack;

  always @(posedge clock) begin
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ack_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (src_q[i].size() > 0) begin
        req[i]                    = 1'b1;
        req_data[i*WIDTH +: WIDTH] = src_q[i][0][7:0];
        req_last[i]               = src_q[i][0][8];
      end else begin
        req[i]                    = 1'b0;
        req_data[i*WIDTH +: WIDTH] = '0;
        req_last[i]               = 1'b0;
      end
    end
  end

  task automatic send(input int idx, input logic [7:0] data, input logic last);
    src_q[idx].push_back({last, data});
  endtask

  task automatic expect_write(input logic [3:0] g, input logic [7:0] data, input logic [7:0] cnt);
    exp_t e;
    e.grant = g;
    e.data  = data;
    e.count = cnt;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n   = 1'b0;
    fifo_full = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) @(negedge clock);
      if (c == 3) reset_n = 1'b1;
      checks++;
      if (grant !== 4'b0000 || fifo_write_en !== 1'b0 || burst_count !== 8'd0 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_idle cycle %0d: grant=%b we=%b count=%0d busy=%b, required 0000/0/0/0",
                 c, grant, fifo_write_en, burst_count, busy);
      end
    end
  endtask

  task automatic test_single_stream();
    exp_t       e;
    logic [11:0] wr_pat;
    wr_pat = 12'b0111_1011_1100;
    do_reset();
    @(negedge clock);
    for (int k = 0; k < 8; k++) begin
      send(2, 8'h10 + 8'(k), 1'b0);
      expect_write(4'b0100, 8'h10 + 8'(k), 8'(k % MAX_BURST));
    end
    for (int c = 1; c <= 11; c++) begin
      @(negedge clock);
      checks++;
      if (fifo_write_en !== wr_pat[c] || grant !== (wr_pat[c] ? 4'b0100 : 4'b0000)) begin
        errors++;
        $display("[TB] FAIL stream_timing cycle %0d: we=%b grant=%b, required we=%b grant=%b",
                 c, fifo_write_en, grant, wr_pat[c], wr_pat[c] ? 4'b0100 : 4'b0000);
      end
      checks++;
      if (ack !== (fifo_write_en ? grant : 4'b0000)) begin
        errors++;
        $display("[TB] FAIL stream_ack: ack=%b, required %b", ack, fifo_write_en ? grant : 4'b0000);
      end
      if (fifo_write_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL stream_extra_write: data=%h, required no write", fifo_write_data);
        end else begin
          e = exp_q.pop_front();
          if (fifo_write_data !== e.data || grant !== e.grant || burst_count !== e.count) begin
            errors++;
            $display("[TB] FAIL stream_word: data=%h grant=%b count=%0d, required data=%h grant=%b count=%0d",
                     fifo_write_data, grant, burst_count, e.data, e.grant, e.count);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL stream_drain: %0d words outstanding, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_round_robin();
    exp_t e;
    do_reset();
    @(negedge clock);
    for (int b = 0; b < 2; b++) begin
      send(0, 8'hA0 + 8'(2*b), 1'b0); send(0, 8'hA1 + 8'(2*b), 1'b1);
      send(1, 8'hB0 + 8'(2*b), 1'b0); send(1, 8'hB1 + 8'(2*b), 1'b1);
      send(3, 8'hD0 + 8'(2*b), 1'b0); send(3, 8'hD1 + 8'(2*b), 1'b1);
      expect_write(4'b0001, 8'hA0 + 8'(2*b), 8'd0); expect_write(4'b0001, 8'hA1 + 8'(2*b), 8'd1);
      expect_write(4'b0010, 8'hB0 + 8'(2*b), 8'd0); expect_write(4'b0010, 8'hB1 + 8'(2*b), 8'd1);
      expect_write(4'b1000, 8'hD0 + 8'(2*b), 8'd0); expect_write(4'b1000, 8'hD1 + 8'(2*b), 8'd1);
    end
    for (int c = 1; c <= 40 && exp_q.size() > 0; c++) begin
      @(negedge clock);
      checks++;
      if (ack !== (fifo_write_en ? grant : 4'b0000)) begin
        errors++;
        $display("[TB] FAIL rr_ack: ack=%b, required %b", ack, fifo_write_en ? grant : 4'b0000);
      end
      if (fifo_write_en) begin
        checks++;
        e = exp_q.pop_front();
        if (fifo_write_data !== e.data || grant !== e.grant || burst_count !== e.count) begin
          errors++;
          $display("[TB] FAIL rr_word: data=%h grant=%b count=%0d, required data=%h grant=%b count=%0d",
                   fifo_write_data, grant, burst_count, e.data, e.grant, e.count);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL rr_timeout: %0d words outstanding, required 0", exp_q.size());
    end
    exp_q.delete();
    repeat (2) @(negedge clock);
  endtask

  task automatic test_backpressure();
    exp_t e;
    do_reset();
    @(negedge clock);
    send(1, 8'h31, 1'b0); send(1, 8'h32, 1'b0); send(1, 8'h33, 1'b1);
    expect_write(4'b0010, 8'h31, 8'd0);
    expect_write(4'b0010, 8'h32, 8'd1);
    expect_write(4'b0010, 8'h33, 8'd2);
    for (int phase = 0; phase < 2; phase++) begin
      if (phase == 1) begin
        @(posedge clock); #1; fifo_full = 1'b1;
        for (int s = 0; s < 2; s++) begin
          @(negedge clock);
          checks++;
          if (fifo_write_en !== 1'b0 || ack !== 4'b0000 || burst_count !== 8'd1 || grant !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL bp_stall: we=%b ack=%b count=%0d grant=%b, required 0/0000/1/0010",
                     fifo_write_en, ack, burst_count, grant);
          end
        end
        @(posedge clock); #1; fifo_full = 1'b0;
      end
      for (int c = 0; c < 2; c++) begin
        @(negedge clock);
        if (fifo_write_en) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL bp_extra_write: data=%h, required no write", fifo_write_data);
          end else begin
            e = exp_q.pop_front();
            if (fifo_write_data !== e.data || grant !== e.grant || burst_count !== e.count) begin
              errors++;
              $display("[TB] FAIL bp_word: data=%h grant=%b count=%0d, required data=%h grant=%b count=%0d",
                       fifo_write_data, grant, burst_count, e.data, e.grant, e.count);
            end
          end
        end
      end
    end
    @(negedge clock);
    checks++;
    if (grant !== 4'b0000 || burst_count !== 8'd0 || busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL bp_end: grant=%b count=%0d busy=%b pending=%0d, required 0000/0/0/0",
               grant, burst_count, busy, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_early_release();
    exp_t       e;
    logic [3:0] g_exp[6];
    g_exp = '{4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
    do_reset();
    @(negedge clock);
    send(3, 8'h40, 1'b0);
    expect_write(4'b1000, 8'h40, 8'd0);
    expect_write(4'b0001, 8'h50, 8'd0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      checks++;
      if (grant !== g_exp[c-1] || busy !== (g_exp[c-1] != 4'b0000)) begin
        errors++;
        $display("[TB] FAIL early_grant cycle %0d: grant=%b busy=%b, required grant=%b",
                 c, grant, busy, g_exp[c-1]);
      end
      if (fifo_write_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL early_extra_write: data=%h, required no write", fifo_write_data);
        end else begin
          e = exp_q.pop_front();
          if (fifo_write_data !== e.data || grant !== e.grant || burst_count !== e.count) begin
            errors++;
            $display("[TB] FAIL early_word: data=%h grant=%b count=%0d, required data=%h grant=%b count=%0d",
                     fifo_write_data, grant, burst_count, e.data, e.grant, e.count);
          end
        end
      end
      if (c == 2) send(0, 8'h50, 1'b1);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL early_drain: %0d words outstanding, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_burst();
    exp_t e;
    do_reset();
    @(negedge clock);
    for (int k = 0; k < 4; k++) send(0, 8'h60 + 8'(k), 1'b0);
    expect_write(4'b0001, 8'h60, 8'd0);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clock);
      if (fifo_write_en) begin
        checks++;
        e = exp_q.pop_front();
        if (fifo_write_data !== e.data || grant !== e.grant || burst_count !== e.count) begin
          errors++;
          $display("[TB] FAIL rst_first_word: data=%h grant=%b count=%0d, required data=%h grant=%b count=%0d",
                   fifo_write_data, grant, burst_count, e.data, e.grant, e.count);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL rst_first_missing: %0d words outstanding, required 0", exp_q.size());
    end
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++;
    if (grant !== 4'b0000 || fifo_write_en !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0 || burst_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL rst_async_clear: grant=%b we=%b ack=%b busy=%b count=%0d, required all zero",
               grant, fifo_write_en, ack, busy, burst_count);
    end
    @(posedge clock); #2;
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    exp_q.delete();
    send(0, 8'h70, 1'b1);
    send(1, 8'h71, 1'b1);
    expect_write(4'b0001, 8'h70, 8'd0);
    expect_write(4'b0010, 8'h71, 8'd0);
    @(negedge clock);
    checks++;
    if (fifo_write_en !== 1'b0 || grant !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL rst_held: we=%b grant=%b, required 0/0000", fifo_write_en, grant);
    end
    reset_n = 1'b1;
    for (int c = 1; c <= 12 && exp_q.size() > 0; c++) begin
      @(negedge clock);
      if (fifo_write_en) begin
        checks++;
        e = exp_q.pop_front();
        if (fifo_write_data !== e.data || grant !== e.grant || burst_count !== e.count) begin
          errors++;
          $display("[TB] FAIL rst_order: data=%h grant=%b count=%0d, required data=%h grant=%b count=%0d",
                   fifo_write_data, grant, burst_count, e.data, e.grant, e.count);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL rst_timeout: %0d words outstanding, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_stream();
    test_round_robin();
    test_backpressure();
    test_early_release();
    test_reset_mid_burst();
    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
